// File: rtl/ahb_arb_pkg.sv
// Shared types for the two-master AHB-Lite arbiter.
// Transfer encodings, per-master FSM states and the address-phase record.
package ahb_arb_pkg;

   // Address width carried in the pending/hold records.
   localparam int AHB_ADDR_W = 32;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DATA = 2'd2
   } mst_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } owner_t;

   typedef struct packed {
      logic [AHB_ADDR_W-1:0] haddr;
      logic                  hwrite;
      logic [2:0]            hsize;
   } addr_phase_t;

   // NONSEQ and SEQ carry a transfer; IDLE and BUSY never do.
   function automatic logic is_xfer(input logic [1:0] htrans);
      logic r;
      unique case (htrans)
         HTRANS_IDLE, HTRANS_BUSY:  r = 1'b0;
         HTRANS_NONSEQ, HTRANS_SEQ: r = 1'b1;
         default:                   r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ahb_arb_input_stage.sv
// Per-master input stage: FSM, pending address register,
// hreadyout/hresp generation and request towards the grant logic.
module ahb_arb_input_stage
   import ahb_arb_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              sim_clock,
   input  logic              power_on_reset_n,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic              s_hready,
   input  logic              s_hresp,
   input  logic              grant,
   input  logic              is_owner,
   output logic              hreadyout,
   output logic              hresp,
   output logic              req,
   output addr_phase_t       src
);

   mst_state_t  state, state_nxt;
   addr_phase_t pend;
   addr_phase_t live_rec;
   logic        pend_valid;
   logic        pend_valid_nxt;
   logic        capture;
   logic        live;

   // Ready/response seen by the master; request gated off in reset.
   always_comb begin
      hreadyout = 1'b1;
      unique case (state)
         ST_IDLE: hreadyout = 1'b1;
         ST_WAIT: hreadyout = 1'b0;
         ST_DATA: hreadyout = s_hready;
         default: hreadyout = 1'b1;
      endcase
      hresp    = is_owner & s_hresp;
      live     = power_on_reset_n & hreadyout & is_xfer(htrans);
      req      = live | (state == ST_WAIT);
      live_rec = '{haddr:  AHB_ADDR_W'(haddr),
                   hwrite: hwrite,
                   hsize:  hsize};
      src      = pend_valid ? pend : live_rec;
   end

   // Next state, pending capture and pending clear.
   always_comb begin
      state_nxt      = state;
      capture        = 1'b0;
      pend_valid_nxt = pend_valid;
      unique case (state)
         ST_IDLE: begin
            if (live) begin
               if (grant) begin
                  state_nxt = ST_DATA;
               end else begin
                  state_nxt      = ST_WAIT;
                  capture        = 1'b1;
                  pend_valid_nxt = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (grant) begin
               state_nxt      = ST_DATA;
               pend_valid_nxt = 1'b0;
            end
         end
         ST_DATA: begin
            if (s_hready) begin
               if (live && grant) begin
                  state_nxt = ST_DATA;
               end else if (live) begin
                  state_nxt      = ST_WAIT;
                  capture        = 1'b1;
                  pend_valid_nxt = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            state_nxt      = ST_IDLE;
            pend_valid_nxt = 1'b0;
         end
      endcase
   end

   // State and pending register.
   always_ff @(posedge sim_clock or negedge power_on_reset_n) begin
      if (!power_on_reset_n) begin
         state      <= ST_IDLE;
         pend_valid <= 1'b0;
         pend       <= '0;
      end else begin
         state      <= state_nxt;
         pend_valid <= pend_valid_nxt;
         if (capture) begin
            pend <= live_rec;
         end
      end
   end

endmodule

// File: rtl/ahb_lite_arbiter_2m.sv
// Two-master AHB-Lite arbiter sharing one zero-wait slave path.
// Grant logic, last grant, data-phase owner, slave hold register, muxes.
module ahb_lite_arbiter_2m
   import ahb_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int FIXED_PRIO = 0
) (
   input  logic              sim_clock,
   input  logic              power_on_reset_n,
   input  logic [ADDR_W-1:0] m0_haddr,
   input  logic [1:0]        m0_htrans,
   input  logic              m0_hwrite,
   input  logic [2:0]        m0_hsize,
   input  logic [DATA_W-1:0] m0_hwdata,
   output logic [DATA_W-1:0] m0_hrdata,
   output logic              m0_hreadyout,
   output logic              m0_hresp,
   input  logic [ADDR_W-1:0] m1_haddr,
   input  logic [1:0]        m1_htrans,
   input  logic              m1_hwrite,
   input  logic [2:0]        m1_hsize,
   input  logic [DATA_W-1:0] m1_hwdata,
   output logic [DATA_W-1:0] m1_hrdata,
   output logic              m1_hreadyout,
   output logic              m1_hresp,
   output logic [ADDR_W-1:0] s_haddr,
   output logic [1:0]        s_htrans,
   output logic              s_hwrite,
   output logic [2:0]        s_hsize,
   output logic [DATA_W-1:0] s_hwdata,
   input  logic [DATA_W-1:0] s_hrdata,
   input  logic              s_hready,
   input  logic              s_hresp
);

   typedef struct packed {
      addr_phase_t rec;
      logic [1:0]  htrans;
   } slv_addr_t;

   logic        req0, req1;
   logic        grant0, grant1;
   addr_phase_t src0, src1;
   owner_t      last_grant;
   owner_t      data_owner;
   slv_addr_t   fwd, hold, s_out;

   ahb_arb_input_stage #(.ADDR_W(ADDR_W)) u_m0 (
      .sim_clock        (sim_clock),
      .power_on_reset_n (power_on_reset_n),
      .haddr            (m0_haddr),
      .htrans           (m0_htrans),
      .hwrite           (m0_hwrite),
      .hsize            (m0_hsize),
      .s_hready         (s_hready),
      .s_hresp          (s_hresp),
      .grant            (grant0),
      .is_owner         (data_owner == OWN_M0),
      .hreadyout        (m0_hreadyout),
      .hresp            (m0_hresp),
      .req              (req0),
      .src              (src0)
   );

   ahb_arb_input_stage #(.ADDR_W(ADDR_W)) u_m1 (
      .sim_clock        (sim_clock),
      .power_on_reset_n (power_on_reset_n),
      .haddr            (m1_haddr),
      .htrans           (m1_htrans),
      .hwrite           (m1_hwrite),
      .hsize            (m1_hsize),
      .s_hready         (s_hready),
      .s_hresp          (s_hresp),
      .grant            (grant1),
      .is_owner         (data_owner == OWN_M1),
      .hreadyout        (m1_hreadyout),
      .hresp            (m1_hresp),
      .req              (req1),
      .src              (src1)
   );

   // Grant only on slave-accepted cycles; ties go round-robin or to M0.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (s_hready) begin
         if (req0 && req1) begin
            if (FIXED_PRIO != 0 || last_grant == OWN_M1) begin
               grant0 = 1'b1;
            end else begin
               grant1 = 1'b1;
            end
         end else if (req0) begin
            grant0 = 1'b1;
         end else if (req1) begin
            grant1 = 1'b1;
         end
      end
   end

   // Forwarded address phase; every transfer leaves as a NONSEQ single.
   always_comb begin
      fwd = '0;
      unique case (1'b1)
         grant0: begin
            fwd.rec    = src0;
            fwd.htrans = HTRANS_NONSEQ;
         end
         grant1: begin
            fwd.rec    = src1;
            fwd.htrans = HTRANS_NONSEQ;
         end
         default: fwd.htrans = HTRANS_IDLE;
      endcase
      s_out = s_hready ? fwd : hold;
   end

   assign s_haddr  = ADDR_W'(s_out.rec.haddr);
   assign s_hwrite = s_out.rec.hwrite;
   assign s_hsize  = s_out.rec.hsize;
   assign s_htrans = s_out.htrans;

   // Write data and responses follow the data-phase owner.
   always_comb begin
      s_hwdata = '0;
      unique case (data_owner)
         OWN_M0:  s_hwdata = m0_hwdata;
         OWN_M1:  s_hwdata = m1_hwdata;
         default: s_hwdata = '0;
      endcase
   end

   assign m0_hrdata = s_hrdata;
   assign m1_hrdata = s_hrdata;

   // Keep a copy of the accepted address phase for slave wait states.
   always_ff @(posedge sim_clock or negedge power_on_reset_n) begin
      if (!power_on_reset_n) begin
         hold <= '0;
      end else if (s_hready) begin
         hold <= fwd;
      end
   end

   // Track last winner and which master owns the next data phase.
   always_ff @(posedge sim_clock or negedge power_on_reset_n) begin
      if (!power_on_reset_n) begin
         last_grant <= OWN_M1;
         data_owner <= OWN_NONE;
      end else if (s_hready) begin
         if (grant0) begin
            last_grant <= OWN_M0;
            data_owner <= OWN_M0;
         end else if (grant1) begin
            last_grant <= OWN_M1;
            data_owner <= OWN_M1;
         end else begin
            data_owner <= OWN_NONE;
         end
      end
   end

endmodule

// File: tb/tb_ahb_lite_arbiter_2m.sv
// Directed testbench for ahb_lite_arbiter_2m.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_ahb_lite_arbiter_2m;

   localparam logic [1:0] T_IDLE = 2'b00;
   localparam logic [1:0] T_NSEQ = 2'b10;
   localparam logic [1:0] T_SEQ  = 2'b11;

   logic        sim_clock = 1'b0;
   logic        power_on_reset_n = 1'b0;
   logic [31:0] m0_haddr, m1_haddr;
   logic [1:0]  m0_htrans, m1_htrans;
   logic        m0_hwrite, m1_hwrite;
   logic [2:0]  m0_hsize, m1_hsize;
   logic [31:0] m0_hwdata, m1_hwdata;
   logic [31:0] m0_hrdata, m1_hrdata;
   logic        m0_hreadyout, m1_hreadyout;
   logic        m0_hresp, m1_hresp;
   logic [31:0] s_haddr;
   logic [1:0]  s_htrans;
   logic        s_hwrite;
   logic [2:0]  s_hsize;
   logic [31:0] s_hwdata;
   logic [31:0] s_hrdata;
   logic        s_hready;
   logic        s_hresp;

   int checks   = 0;
   int failures = 0;

   always #5 sim_clock = ~sim_clock;

   ahb_lite_arbiter_2m #(
      .ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)
   ) dut (
      .sim_clock        (sim_clock),
      .power_on_reset_n (power_on_reset_n),
      .m0_haddr         (m0_haddr),
      .m0_htrans        (m0_htrans),
      .m0_hwrite        (m0_hwrite),
      .m0_hsize         (m0_hsize),
      .m0_hwdata        (m0_hwdata),
      .m0_hrdata        (m0_hrdata),
      .m0_hreadyout     (m0_hreadyout),
      .m0_hresp         (m0_hresp),
      .m1_haddr         (m1_haddr),
      .m1_htrans        (m1_htrans),
      .m1_hwrite        (m1_hwrite),
      .m1_hsize         (m1_hsize),
      .m1_hwdata        (m1_hwdata),
      .m1_hrdata        (m1_hrdata),
      .m1_hreadyout     (m1_hreadyout),
      .m1_hresp         (m1_hresp),
      .s_haddr          (s_haddr),
      .s_htrans         (s_htrans),
      .s_hwrite         (s_hwrite),
      .s_hsize          (s_hsize),
      .s_hwdata         (s_hwdata),
      .s_hrdata         (s_hrdata),
      .s_hready         (s_hready),
      .s_hresp          (s_hresp)
   );

   task automatic tick;
      @(posedge sim_clock);
      #1;
   endtask

   task automatic sample;
      @(negedge sim_clock);
   endtask

   task automatic idle_masters;
      m0_htrans = T_IDLE;
      m1_htrans = T_IDLE;
      m0_haddr  = '0;
      m1_haddr  = '0;
      m0_hwrite = 1'b0;
      m1_hwrite = 1'b0;
      m0_hsize  = 3'd2;
      m1_hsize  = 3'd2;
   endtask

   task automatic apply_reset;
      power_on_reset_n = 1'b0;
      idle_masters();
      m0_hwdata = '0;
      m1_hwdata = '0;
      s_hrdata  = '0;
      s_hready  = 1'b1;
      s_hresp   = 1'b0;
      repeat (2) @(posedge sim_clock);
      #1;
      power_on_reset_n = 1'b1;
   endtask

   task automatic test_reset;
      apply_reset();
      power_on_reset_n = 1'b0;
      m0_htrans = T_NSEQ;
      m0_haddr  = 32'h55;
      #1;
      checks++;
      if (s_htrans !== T_IDLE) begin
         failures++;
         $display("FAIL rst_htrans got=%b exp=%b", s_htrans, T_IDLE);
      end
      checks++;
      if (m0_hreadyout !== 1'b1 || m1_hreadyout !== 1'b1) begin
         failures++;
         $display("FAIL rst_ready got=%b%b exp=11",
                  m0_hreadyout, m1_hreadyout);
      end
      checks++;
      if (m0_hresp !== 1'b0 || m1_hresp !== 1'b0) begin
         failures++;
         $display("FAIL rst_resp got=%b%b exp=00", m0_hresp, m1_hresp);
      end
      checks++;
      if (s_haddr !== 32'h0 || s_hwrite !== 1'b0 || s_hsize !== 3'd0) begin
         failures++;
         $display("FAIL rst_addr got=%h/%b/%0d exp=0/0/0",
                  s_haddr, s_hwrite, s_hsize);
      end
      idle_masters();
      tick();
      power_on_reset_n = 1'b1;
      sample();
      checks++;
      if (s_htrans !== T_IDLE) begin
         failures++;
         $display("FAIL rst_rel_htrans got=%b exp=%b", s_htrans, T_IDLE);
      end
      tick();
   endtask

   task automatic test_single_master;
      apply_reset();
      m0_htrans = T_NSEQ;
      m0_haddr  = 32'h100;
      m0_hwrite = 1'b0;
      sample();
      checks++;
      if (s_htrans !== T_NSEQ || s_haddr !== 32'h100
          || s_hwrite !== 1'b0) begin
         failures++;
         $display("FAIL single_rd got=%b/%h/%b exp=10/00000100/0",
                  s_htrans, s_haddr, s_hwrite);
      end
      checks++;
      if (m0_hreadyout !== 1'b1 || m1_hreadyout !== 1'b1) begin
         failures++;
         $display("FAIL single_rdy0 got=%b%b exp=11",
                  m0_hreadyout, m1_hreadyout);
      end
      tick();
      m0_haddr  = 32'h104;
      m0_hwrite = 1'b1;
      s_hrdata  = 32'h0000_1234;
      sample();
      checks++;
      if (s_htrans !== T_NSEQ || s_haddr !== 32'h104
          || s_hwrite !== 1'b1) begin
         failures++;
         $display("FAIL single_wr got=%b/%h/%b exp=10/00000104/1",
                  s_htrans, s_haddr, s_hwrite);
      end
      checks++;
      if (m0_hreadyout !== 1'b1 || m0_hrdata !== 32'h0000_1234) begin
         failures++;
         $display("FAIL single_rdy1 got=%b/%h exp=1/00001234",
                  m0_hreadyout, m0_hrdata);
      end
      tick();
      idle_masters();
      m0_hwdata = 32'hDEAD_BEEF;
      sample();
      checks++;
      if (s_hwdata !== 32'hDEAD_BEEF || s_htrans !== T_IDLE) begin
         failures++;
         $display("FAIL single_wdata got=%h/%b exp=deadbeef/00",
                  s_hwdata, s_htrans);
      end
      checks++;
      if (m0_hreadyout !== 1'b1 || m1_hreadyout !== 1'b1) begin
         failures++;
         $display("FAIL single_rdy2 got=%b%b exp=11",
                  m0_hreadyout, m1_hreadyout);
      end
      tick();
   endtask

   task automatic test_contention;
      apply_reset();
      m0_htrans = T_NSEQ;
      m0_haddr  = 32'h200;
      m0_hwrite = 1'b1;
      m1_htrans = T_NSEQ;
      m1_haddr  = 32'h300;
      m1_hwrite = 1'b1;
      sample();
      checks++;
      if (s_haddr !== 32'h200 || s_htrans !== T_NSEQ) begin
         failures++;
         $display("FAIL cont_first got=%h/%b exp=00000200/10",
                  s_haddr, s_htrans);
      end
      checks++;
      if (m1_hreadyout !== 1'b1) begin
         failures++;
         $display("FAIL cont_m1rdy0 got=%b exp=1", m1_hreadyout);
      end
      tick();
      idle_masters();
      m0_hwdata = 32'hAAAA_0000;
      m1_hwdata = 32'hBBBB_0000;
      sample();
      checks++;
      if (s_haddr !== 32'h300 || s_htrans !== T_NSEQ
          || s_hwrite !== 1'b1) begin
         failures++;
         $display("FAIL cont_second got=%h/%b/%b exp=00000300/10/1",
                  s_haddr, s_htrans, s_hwrite);
      end
      checks++;
      if (m1_hreadyout !== 1'b0 || m0_hreadyout !== 1'b1) begin
         failures++;
         $display("FAIL cont_rdy1 got=m0 %b m1 %b exp=m0 1 m1 0",
                  m0_hreadyout, m1_hreadyout);
      end
      checks++;
      if (s_hwdata !== 32'hAAAA_0000) begin
         failures++;
         $display("FAIL cont_wdata0 got=%h exp=aaaa0000", s_hwdata);
      end
      tick();
      sample();
      checks++;
      if (m1_hreadyout !== 1'b1 || s_hwdata !== 32'hBBBB_0000
          || s_htrans !== T_IDLE) begin
         failures++;
         $display("FAIL cont_wdata1 got=%b/%h/%b exp=1/bbbb0000/00",
                  m1_hreadyout, s_hwdata, s_htrans);
      end
      tick();
   endtask

   task automatic test_back_to_back;
      logic [1:0]  t0 [6] = '{T_NSEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_IDLE};
      logic [31:0] a0 [6] = '{32'h1000, 32'h1004, 32'h1008,
                              32'h1008, 32'h100C, 32'h0};
      logic [1:0]  t1 [6] = '{T_IDLE, T_NSEQ, T_IDLE,
                              T_IDLE, T_IDLE, T_IDLE};
      logic [31:0] ea [5] = '{32'h1000, 32'h2000, 32'h1004,
                              32'h1008, 32'h100C};
      logic        er [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         m0_htrans = t0[i];
         m0_haddr  = a0[i];
         m1_htrans = t1[i];
         m1_haddr  = 32'h2000;
         sample();
         if (i < 5) begin
            checks++;
            if (s_haddr !== ea[i] || s_htrans !== T_NSEQ) begin
               failures++;
               $display("FAIL b2b_addr%0d got=%h/%b exp=%h/10",
                        i, s_haddr, s_htrans, ea[i]);
            end
         end else begin
            checks++;
            if (s_htrans !== T_IDLE) begin
               failures++;
               $display("FAIL b2b_idle got=%b exp=00", s_htrans);
            end
         end
         checks++;
         if (m0_hreadyout !== er[i]) begin
            failures++;
            $display("FAIL b2b_rdy%0d got=%b exp=%b",
                     i, m0_hreadyout, er[i]);
         end
         tick();
      end
      idle_masters();
   endtask

   task automatic test_slave_wait;
      apply_reset();
      m0_htrans = T_NSEQ;
      m0_haddr  = 32'h400;
      sample();
      checks++;
      if (s_haddr !== 32'h400 || s_htrans !== T_NSEQ) begin
         failures++;
         $display("FAIL wait_first got=%h/%b exp=00000400/10",
                  s_haddr, s_htrans);
      end
      tick();
      m0_htrans = T_IDLE;
      m1_htrans = T_NSEQ;
      m1_haddr  = 32'h500;
      s_hready  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sample();
         checks++;
         if (s_haddr !== 32'h400 || s_htrans !== T_NSEQ
             || m0_hreadyout !== 1'b0) begin
            failures++;
            $display("FAIL wait_hold%0d got=%h/%b/%b exp=00000400/10/0",
                     i, s_haddr, s_htrans, m0_hreadyout);
         end
         tick();
         m1_htrans = T_IDLE;
      end
      s_hready = 1'b1;
      sample();
      checks++;
      if (s_haddr !== 32'h500 || s_htrans !== T_NSEQ) begin
         failures++;
         $display("FAIL wait_m1 got=%h/%b exp=00000500/10",
                  s_haddr, s_htrans);
      end
      checks++;
      if (m0_hreadyout !== 1'b1 || m1_hreadyout !== 1'b0) begin
         failures++;
         $display("FAIL wait_rdy got=%b%b exp=10",
                  m0_hreadyout, m1_hreadyout);
      end
      tick();
      sample();
      checks++;
      if (m1_hreadyout !== 1'b1 || s_htrans !== T_IDLE) begin
         failures++;
         $display("FAIL wait_done got=%b/%b exp=1/00",
                  m1_hreadyout, s_htrans);
      end
      tick();
   endtask

   task automatic test_error;
      apply_reset();
      m1_htrans = T_NSEQ;
      m1_haddr  = 32'h600;
      tick();
      m1_htrans = T_IDLE;
      m0_htrans = T_NSEQ;
      m0_haddr  = 32'h700;
      s_hready  = 1'b0;
      s_hresp   = 1'b1;
      sample();
      checks++;
      if (m1_hresp !== 1'b1 || m0_hresp !== 1'b0
          || m1_hreadyout !== 1'b0) begin
         failures++;
         $display("FAIL err_c1 got=r1 %b r0 %b rdy1 %b exp=1 0 0",
                  m1_hresp, m0_hresp, m1_hreadyout);
      end
      tick();
      m0_htrans = T_IDLE;
      s_hready  = 1'b1;
      sample();
      checks++;
      if (m1_hresp !== 1'b1 || m0_hresp !== 1'b0
          || m1_hreadyout !== 1'b1) begin
         failures++;
         $display("FAIL err_c2 got=r1 %b r0 %b rdy1 %b exp=1 0 1",
                  m1_hresp, m0_hresp, m1_hreadyout);
      end
      checks++;
      if (s_haddr !== 32'h700 || s_htrans !== T_NSEQ) begin
         failures++;
         $display("FAIL err_m0_issue got=%h/%b exp=00000700/10",
                  s_haddr, s_htrans);
      end
      tick();
      s_hresp = 1'b0;
      sample();
      checks++;
      if (m1_hresp !== 1'b0 || m0_hreadyout !== 1'b1) begin
         failures++;
         $display("FAIL err_after got=%b/%b exp=0/1",
                  m1_hresp, m0_hreadyout);
      end
      tick();
   endtask

   task automatic test_reset_mid_wait;
      apply_reset();
      m0_htrans = T_NSEQ;
      m0_haddr  = 32'h800;
      m1_htrans = T_NSEQ;
      m1_haddr  = 32'h900;
      tick();
      idle_masters();
      s_hready = 1'b0;
      #1;
      checks++;
      if (m1_hreadyout !== 1'b0) begin
         failures++;
         $display("FAIL rmw_inwait got=%b exp=0", m1_hreadyout);
      end
      power_on_reset_n = 1'b0;
      #1;
      checks++;
      if (m0_hreadyout !== 1'b1 || m1_hreadyout !== 1'b1
          || s_htrans !== T_IDLE) begin
         failures++;
         $display("FAIL rmw_async got=%b%b/%b exp=11/00",
                  m0_hreadyout, m1_hreadyout, s_htrans);
      end
      tick();
      power_on_reset_n = 1'b1;
      s_hready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sample();
         checks++;
         if (s_htrans !== T_IDLE || m1_hreadyout !== 1'b1) begin
            failures++;
            $display("FAIL rmw_post%0d got=%b/%b exp=00/1",
                     i, s_htrans, m1_hreadyout);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single_master();
      test_contention();
      test_back_to_back();
      test_slave_wait();
      test_error();
      test_reset_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ahb_lite_arbiter_2m.md
Name: ahb_lite_arbiter_2m

Overview:
- Two-master AHB-Lite arbiter/input stage that shares the single zero-wait-state memory and console slave path between master 0 (CPU) and master 1 (RAM loader/DMA).
- Each master sees a private AHB-Lite slave port; a non-granted master's address phase is buffered and its data phase is stretched with HREADYOUT low.
- Round-robin or fixed-priority arbitration, decided per slave-accepted address phase.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins ties.

Ports:
- sim_clock  in  1  clock
- power_on_reset_n  in  1  reset; asynchronous, active-low
- m0_haddr / m1_haddr  in  ADDR_W  master address
- m0_htrans / m1_htrans  in  2  master transfer type
- m0_hwrite / m1_hwrite  in  1  master write flag
- m0_hsize / m1_hsize  in  3  master transfer size
- m0_hwdata / m1_hwdata  in  DATA_W  master write data
- m0_hrdata / m1_hrdata  out  DATA_W  read data to master
- m0_hreadyout / m1_hreadyout  out  1  ready to master
- m0_hresp / m1_hresp  out  1  error response to master
- s_haddr  out  ADDR_W  slave address
- s_htrans  out  2  slave transfer type
- s_hwrite  out  1  slave write flag
- s_hsize  out  3  slave transfer size
- s_hwdata  out  DATA_W  slave write data
- s_hrdata  in  DATA_W  slave read data
- s_hready  in  1  slave ready
- s_hresp  in  1  slave error response

Behaviour:
- Reset (async, power_on_reset_n=0):
  - m*_hreadyout=1, m*_hresp=0.
  - s_htrans=IDLE(2'b00), s_haddr=0, s_hwrite=0, s_hsize=0.
  - Pending registers invalid; data_owner=NONE; last_grant=M1, so M0 wins the first tie.
  - Assertion mid-transfer drops all outstanding and pending transfers immediately.
- Live request: m_htrans[1]=1 (NONSEQ/SEQ) while m_hreadyout=1. IDLE/BUSY are never forwarded or captured.
- Per-master FSM, states IDLE, WAIT, DATA; m_hreadyout is 1 in IDLE, 0 in WAIT, s_hready in DATA.
  - IDLE: live request and granted -> DATA. Live request not granted -> WAIT, capturing haddr/hwrite/hsize into the pending register.
  - WAIT: granted -> DATA, with the address taken from the pending register; pending cleared.
  - DATA with s_hready=1: new live request granted -> DATA; not granted -> WAIT (capture); none -> IDLE.
  - DATA with s_hready=0: hold state.
- Arbitration:
  - Evaluated only in cycles with s_hready=1. Candidates are masters in WAIT or presenting a live request.
  - Round-robin: a lone candidate wins. With two candidates, the master != last_grant wins. last_grant updates on every grant.
  - FIXED_PRIO=1: M0 wins ties.
  - Starvation bound with round-robin: one foreign transfer.
- Slave address phase:
  - When s_hready=1, s_* comes combinationally from the granted source (pending register if valid, else live bus). s_htrans=NONSEQ for every forwarded transfer; bursts are broken into singles.
  - No grant -> s_htrans=IDLE.
  - When s_hready=0, s_* holds the registered copy from the last accepted cycle; no grant changes occur.
  - A live request arriving while s_hready=0 goes to WAIT.
- Data phase:
  - data_owner is registered on each accepted NONSEQ (cleared to NONE on accepted IDLE).
  - s_hwdata = hwdata of data_owner; the master holds HWDATA stable while its hreadyout is 0.
  - m_hrdata = s_hrdata for both masters; only the owner samples it.
  - m_hresp = s_hresp for the owner, 0 for the other.
  - A two-cycle ERROR passes through unchanged. The other master's pending transfer is unaffected and is issued afterwards.
- Latency: a lone master, or a master winning in IDLE, adds zero wait states. A losing master sees at least one extra wait state per conflicting foreign transfer.
- Unsupported: HMASTLOCK (not forwarded); HBURST/HPROT are not ports.

Decomposition:
- Package ahb_arb_pkg:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ.
  - Master FSM state encoding IDLE/WAIT/DATA.
  - Owner encoding NONE/M0/M1.
  - Address-phase record typedef {haddr, hwrite, hsize}.
- Sub-module ahb_arb_input_stage, instanced twice: per-master FSM, pending register, hreadyout/hresp generation, request output.
- The top holds the grant logic, last_grant, data_owner, slave hold register and muxes.

Test Plan:
- M0 alone does a read at 0x100 then a write at 0x104, s_hready=1 -> s_htrans=NONSEQ on consecutive cycles; m0_hreadyout never 0; m1_hreadyout=1.
- Both masters issue NONSEQ in the same cycle after reset (M0 0x200, M1 0x300) -> s_haddr=0x200, then 0x300 on the next cycle. m1_hreadyout=0 for exactly one cycle. s_hwdata follows the owner.
- M0 streams 4 back-to-back transfers while M1 requests once -> M1 is issued after at most one M0 transfer; M0 stalls one cycle.
- Slave inserts 2 wait states (s_hready=0) on an M0 transfer while M1 requests -> s_* stable for 2 cycles, then M1 is issued; no pending loss.
- Slave ERROR to M1 (s_hresp=1, s_hready 0 then 1) -> m1_hresp=1 for 2 cycles, m0_hresp=0; M0's pending transfer is issued after.
- power_on_reset_n=0 mid-WAIT -> all hreadyout=1 and s_htrans=IDLE immediately; after release the pending transfer is not issued.
